// File: rtl/half_vec_max_abs_ctrl.sv
// Streams a vector of half-precision elements and reports the largest magnitude, its sign and its index.
// Optional NaN handling is enabled by defining HALF_VEC_MAX_ABS_NAN_EN.
module half_vec_max_abs_ctrl #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      max_abs,
  output logic             max_sign,
  output logic [IDX_W-1:0] max_idx,
  output logic             nan_seen,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  // Magnitude order: exponent then mantissa, i.e. bits [14:0] as unsigned.
  function automatic logic mag_gt(input logic [15:0] a, input logic [15:0] b);
    mag_gt = (a[14:0] > b[14:0]);
  endfunction

  logic [1:0]       state_q,     state_d;
  logic [IDX_W-1:0] len_q,       len_d;
  logic [IDX_W-1:0] count_q,     count_d;
  logic [15:0]      max_abs_q,   max_abs_d;
  logic             max_sign_q,  max_sign_d;
  logic [IDX_W-1:0] max_idx_q,   max_idx_d;
  logic             nan_seen_q,  nan_seen_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  logic             accept_s;
  logic             replace_s;
  logic             elem_nan_s;

  assign accept_s = in_valid && in_ready_q;

`ifdef HALF_VEC_MAX_ABS_NAN_EN
  function automatic logic is_nan(input logic [15:0] h);
    is_nan = (h[14:10] == 5'h1F) && (h[9:0] != 10'h000);
  endfunction

  // Tracks whether the running result currently holds a provisional NaN.
  logic res_nan_q, res_nan_d;

  // NaNs never win; a provisional NaN result loses to any non-NaN element.
  always_comb begin
    elem_nan_s = is_nan(in_data);
    if (count_q == IDX_ZERO) begin
      replace_s = 1'b1;
    end else if (elem_nan_s) begin
      replace_s = 1'b0;
    end else if (res_nan_q) begin
      replace_s = 1'b1;
    end else begin
      replace_s = mag_gt(in_data, max_abs_q);
    end
    if (accept_s && replace_s) begin
      res_nan_d = elem_nan_s;
    end else begin
      res_nan_d = res_nan_q;
    end
  end

  // Provisional-NaN flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_nan_q <= 1'b0;
    end else begin
      res_nan_q <= res_nan_d;
    end
  end
`else
  // Plain raw-magnitude compare; NaNs order above Inf.
  always_comb begin
    elem_nan_s = 1'b0;
    if (count_q == IDX_ZERO) begin
      replace_s = 1'b1;
    end else begin
      replace_s = mag_gt(in_data, max_abs_q);
    end
  end
`endif

  // Next-state and result-update logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    max_abs_d  = max_abs_q;
    max_sign_d = max_sign_q;
    max_idx_d  = max_idx_q;
    nan_seen_d = nan_seen_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d    = IDX_ZERO;
          nan_seen_d = 1'b0;
          if (len == IDX_ZERO) begin
            max_abs_d  = 16'h0000;
            max_sign_d = 1'b0;
            max_idx_d  = IDX_ZERO;
            state_d    = S_DONE;
          end else begin
            len_d   = len;
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (accept_s) begin
          count_d = count_q + IDX_ONE;
          if (elem_nan_s) begin
            nan_seen_d = 1'b1;
          end else begin
            nan_seen_d = nan_seen_q;
          end
          if (replace_s) begin
            max_abs_d  = {1'b0, in_data[14:0]};
            max_sign_d = in_data[15];
            max_idx_d  = count_q;
          end else begin
            max_abs_d  = max_abs_q;
          end
          if (count_q == (len_q - IDX_ONE)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_ACCUM);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, result and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= IDX_ZERO;
      count_q     <= IDX_ZERO;
      max_abs_q   <= 16'h0000;
      max_sign_q  <= 1'b0;
      max_idx_q   <= IDX_ZERO;
      nan_seen_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      max_abs_q   <= max_abs_d;
      max_sign_q  <= max_sign_d;
      max_idx_q   <= max_idx_d;
      nan_seen_q  <= nan_seen_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign max_abs   = max_abs_q;
  assign max_sign  = max_sign_q;
  assign max_idx   = max_idx_q;
  assign nan_seen  = nan_seen_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_half_vec_max_abs_ctrl.sv
// Table-driven, scoreboard-checked bench for half_vec_max_abs_ctrl.
module tb_half_vec_max_abs_ctrl;

  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] len;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      max_abs;
  logic             max_sign;
  logic [IDX_W-1:0] max_idx;
  logic             nan_seen;
  logic             busy;

  half_vec_max_abs_ctrl #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .max_abs(max_abs), .max_sign(max_sign), .max_idx(max_idx),
    .nan_seen(nan_seen), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      abs;
    logic             sgn;
    logic [IDX_W-1:0] idx;
    logic             nan;
  } res_t;

  typedef struct {
    logic [IDX_W-1:0] len;
    logic [3:0][15:0] e;
    res_t             exp;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[8];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int l, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3,
                              input logic [15:0] a, input logic s, input int i, input logic n);
    vec_t v;
    v.len = l[IDX_W-1:0];
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.exp.abs = a; v.exp.sgn = s; v.exp.idx = i[IDX_W-1:0]; v.exp.nan = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [IDX_W-1:0] l, input res_t r);
    start = 1'b1;
    len   = l;
    exp_q.push_back(r);
    tick();
    start = 1'b0;
  endtask

  // Presents one element and returns just after the edge that accepts it.
  task automatic feed(input logic [15:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      chk("feed_timeout", 32'd1, 32'd0);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Pops the expected result and compares once out_valid is seen.
  task automatic check_result(input string nm);
    res_t r;
    int t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    chk({nm, "_out_valid"}, out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      r = exp_q.pop_front();
      chk({nm, "_max_abs"}, max_abs, r.abs);
      chk({nm, "_max_sign"}, max_sign, r.sgn);
      chk({nm, "_max_idx"}, max_idx, r.idx);
      chk({nm, "_nan_seen"}, nan_seen, r.nan);
    end
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_out_valid_clr"}, out_valid, 1'b0);
    chk({nm, "_busy_clr"}, busy, 1'b0);
  endtask

  res_t r_nan;
  res_t r_tmp;
  logic [15:0] held_abs;
  logic [IDX_W-1:0] held_idx;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HALF_VEC_MAX_ABS_NAN_EN
    r_nan = '{16'h3C00, 1'b0, 8'd1, 1'b1};
`else
    r_nan = '{16'h7E00, 1'b0, 8'd0, 1'b0};
`endif
    vecs[0] = mk(4, 16'h3C00, 16'hC500, 16'h4000, 16'h4500, 16'h4500, 1'b1, 1, 1'b0);
    vecs[1] = mk(3, 16'h0001, 16'h8400, 16'h03FF, 16'h0000, 16'h0400, 1'b1, 1, 1'b0);
    vecs[2] = mk(2, 16'h7C00, 16'hFC00, 16'h0000, 16'h0000, 16'h7C00, 1'b0, 0, 1'b0);
    vecs[3] = mk(3, 16'h7E00, 16'h3C00, 16'h7C01, 16'h0000, r_nan.abs, r_nan.sgn, int'(r_nan.idx), r_nan.nan);
    vecs[4] = mk(2, 16'h3C00, 16'hB800, 16'h0000, 16'h0000, 16'h3C00, 1'b0, 0, 1'b0);
    vecs[5] = mk(1, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b1, 0, 1'b0);
    vecs[6] = mk(4, 16'h0000, 16'h8000, 16'h0000, 16'h0001, 16'h0001, 1'b0, 3, 1'b0);
    vecs[7] = mk(3, 16'h3C00, 16'hBC00, 16'h3C00, 16'h0000, 16'h3C00, 1'b0, 0, 1'b0);

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_max_abs", max_abs, 16'h0000);

    // Back-to-back table vectors, each start the cycle after the previous handshake.
    for (int v = 0; v < 8; v++) begin
      do_start(vecs[v].len, vecs[v].exp);
      chk($sformatf("v%0d_in_ready_after_start", v), in_ready, 1'b1);
      chk($sformatf("v%0d_busy", v), busy, 1'b1);
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        feed(vecs[v].e[k]);
      end
      chk($sformatf("v%0d_latency_out_valid", v), out_valid, 1'b1);
      chk($sformatf("v%0d_in_ready_done", v), in_ready, 1'b0);
      check_result($sformatf("v%0d", v));
      handshake($sformatf("v%0d", v));
    end

    // Stalled input, held output, ignored starts during DONE and at the handshake.
    r_tmp = '{16'h0400, 1'b1, 8'd1, 1'b0};
    do_start(8'd3, r_tmp);
    feed(16'h0001); tick(); tick();
    chk("stall_in_ready", in_ready, 1'b1);
    feed(16'h8400); tick(); tick();
    feed(16'h03FF);
    check_result("stall");
    held_abs = max_abs;
    held_idx = max_idx;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      len   = 8'd1;
      tick();
      start = 1'b0;
      chk($sformatf("hold%0d_out_valid", c), out_valid, 1'b1);
      chk($sformatf("hold%0d_max_abs", c), max_abs, held_abs);
      chk($sformatf("hold%0d_max_idx", c), max_idx, held_idx);
      chk($sformatf("hold%0d_in_ready", c), in_ready, 1'b0);
    end
    start = 1'b1;
    handshake("stall");
    start = 1'b0;
    tick();
    chk("start_at_handshake_ignored_busy", busy, 1'b0);
    chk("start_at_handshake_ignored_in_ready", in_ready, 1'b0);
    chk("result_held_in_idle", max_abs, 16'h0400);

    // Empty vector.
    r_tmp = '{16'h0000, 1'b0, 8'd0, 1'b0};
    do_start(8'd0, r_tmp);
    chk("len0_in_ready", in_ready, 1'b0);
    check_result("len0");
    tick();
    chk("len0_in_ready_later", in_ready, 1'b0);
    handshake("len0");

    // Reset mid-vector, then a fresh vector.
    r_tmp = '{16'h4500, 1'b0, 8'd0, 1'b0};
    do_start(8'd5, r_tmp);
    feed(16'h4500);
    feed(16'h3C00);
    void'(exp_q.pop_back());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_max_abs", max_abs, 16'h0000);
    chk("midrst_max_sign", max_sign, 1'b0);
    chk("midrst_max_idx", max_idx, 8'd0);
    chk("midrst_nan_seen", nan_seen, 1'b0);
    r_tmp = '{16'h7C00, 1'b0, 8'd0, 1'b0};
    do_start(8'd2, r_tmp);
    feed(16'h7C00);
    feed(16'hFC00);
    check_result("post_rst");
    handshake("post_rst");

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
